// File: rtl/axis_tx_pkg.sv
// ---------------------------------------------------------------------------
// axis_tx_pkg
//   Shared definitions for the AXI-Lite to AXI-Stream transmit FIFO:
//   register offsets and word indices, response codes, CONTROL/STATUS bit
//   positions, the default read value and the write/read FSM state types.
// ---------------------------------------------------------------------------
package axis_tx_pkg;

  // Byte offsets of the register map
  localparam logic [5:0] OFS_CTRL   = 6'h00;
  localparam logic [5:0] OFS_STAT   = 6'h04;
  localparam logic [5:0] OFS_TXDATA = 6'h08;
  localparam logic [5:0] OFS_TXLAST = 6'h0C;

  // The block decodes addr[5:2] only, so every offset reduces to a word index
  function automatic logic [3:0] regIndex(input logic [5:0] ofs);
    return ofs[5:2];
  endfunction

  localparam logic [3:0] IDX_CTRL   = regIndex(OFS_CTRL);
  localparam logic [3:0] IDX_STAT   = regIndex(OFS_STAT);
  localparam logic [3:0] IDX_TXDATA = regIndex(OFS_TXDATA);
  localparam logic [3:0] IDX_TXLAST = regIndex(OFS_TXLAST);

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // CONTROL and STATUS bit positions
  localparam int BIT_FLUSH = 0;
  localparam int BIT_TX_EN = 1;
  localparam int BIT_FULL  = 16;
  localparam int BIT_EMPTY = 17;
  localparam int BIT_OVF   = 18;

  // Returned for write-only and unmapped addresses
  localparam logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } writeState_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } readState_t;

endpackage

// File: rtl/axis_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with extra-bit wrapping pointers. A push into a full
//   FIFO or a pop from an empty one is ignored; fullness is judged on the
//   occupancy before any pop of the same cycle. Flush empties the FIFO and
//   wins over a push or pop in the same cycle.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push         write i_pushData at the tail
//   i_pushData     entry to write
//   i_pop          discard the head entry
//   i_flush        empty the FIFO
//   o_headData     current head entry (meaningful only while !o_empty)
//   o_full         occupancy == DEPTH
//   o_empty        occupancy == 0
//   o_count        occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_pushData,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_headData,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wrPtr;
  logic [PTR_W:0]   r_rdPtr;
  logic             w_pushOk;
  logic             w_popOk;

  // The pointers carry one extra bit, so their difference is the occupancy
  // even after wrapping, and full/empty are never ambiguous.
  assign o_count    = r_wrPtr - r_rdPtr;
  assign o_full     = (o_count == FULL_COUNT);
  assign o_empty    = (o_count == '0);
  assign w_pushOk   = i_push && !o_full;
  assign w_popOk    = i_pop && !o_empty;
  assign o_headData = r_mem[r_rdPtr[PTR_W-1:0]];

  // Pointer update: flush has priority, otherwise push and pop move their
  // own pointer independently so a simultaneous push/pop keeps occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_popOk)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_pushOk && !i_flush) r_mem[r_wrPtr[PTR_W-1:0]] <= i_pushData;
  end

endmodule

// File: rtl/axis_tx_fifo.sv
// ---------------------------------------------------------------------------
// axis_tx_fifo
//   AXI-Lite slave register block that lets software push words (optionally
//   tagged with tlast) into an internal FIFO, which drains in order onto an
//   AXI-Stream master port.
//
// Registers (decoded on addr[5:2]):
//   0x00 CONTROL  bit0 FLUSH (self-clearing), bit1 TX_EN
//   0x04 STATUS   [15:0] occupancy, bit16 full, bit17 empty, bit18 overflow
//   0x08 TXDATA   write pushes {tlast=0, wdata}
//   0x0C TXLAST   write pushes {tlast=1, wdata}
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   s_axi_aw* / w* / b* AXI-Lite write address, data and response channels
//   s_axi_ar* / r*      AXI-Lite read address and data channels
//   m_axis_*            AXI-Stream master (tdata, tlast, tvalid, tready)
// ---------------------------------------------------------------------------
module axis_tx_fifo
  import axis_tx_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  writeState_t           r_writeState;
  writeState_t           w_writeNext;
  readState_t            r_readState;
  readState_t            w_readNext;

  logic                  r_awHeld;
  logic [3:0]            r_awIdx;
  logic                  r_wHeld;
  logic [DATA_WIDTH-1:0] r_wData;
  logic                  r_wStrb0;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_txEn;
  logic                  r_overflow;
  logic                  r_hold;

  logic                  w_awFire;
  logic                  w_wFire;
  logic                  w_arFire;
  logic                  w_doWrite;
  logic [3:0]            w_wrIdx;
  logic [DATA_WIDTH-1:0] w_wrData;
  logic                  w_wrStrb0;
  logic                  w_ctrlWrite;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pushLast;
  logic                  w_pushDrop;
  logic                  w_pop;
  logic                  w_tvalid;
  logic [DATA_WIDTH-1:0] w_readValue;

  logic [DATA_WIDTH:0]   w_fifoHead;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;
  logic [CNT_W-1:0]      w_fifoCount;

  logic                  w_unused;

  // Address bits outside [5:2] and the upper strobes take no part in decode.
  assign w_unused = ^{s_axi_awaddr[ADDR_WIDTH-1:6], s_axi_awaddr[1:0],
                      s_axi_araddr[ADDR_WIDTH-1:6], s_axi_araddr[1:0],
                      s_axi_wstrb[STRB_W-1:1]};

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_writeState <= W_IDLE;
    else        r_writeState <= w_writeNext;
  end

  // Write FSM next state and handshake outputs. In idle, AW and W are taken
  // independently; the write fires in the cycle both are available, either
  // from the holding registers or straight from the bus.
  always_comb begin
    w_writeNext   = r_writeState;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    w_doWrite     = 1'b0;
    case (r_writeState)
      W_IDLE: begin
        s_axi_awready = !r_awHeld;
        s_axi_wready  = !r_wHeld;
        if ((r_awHeld || s_axi_awvalid) && (r_wHeld || s_axi_wvalid)) begin
          w_doWrite   = 1'b1;
          w_writeNext = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_writeNext = W_IDLE;
      end
      default: w_writeNext = W_IDLE;
    endcase
  end

  assign w_awFire  = s_axi_awvalid && s_axi_awready;
  assign w_wFire   = s_axi_wvalid && s_axi_wready;
  assign w_wrIdx   = r_awHeld ? r_awIdx  : s_axi_awaddr[5:2];
  assign w_wrData  = r_wHeld  ? r_wData  : s_axi_wdata;
  assign w_wrStrb0 = r_wHeld  ? r_wStrb0 : s_axi_wstrb[0];

  // Holding registers for whichever of AW/W arrives first, plus the write
  // response code, which is decided in the cycle the write executes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awHeld <= 1'b0;
      r_awIdx  <= '0;
      r_wHeld  <= 1'b0;
      r_wData  <= '0;
      r_wStrb0 <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_doWrite) begin
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_bresp  <= w_pushDrop ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (w_awFire) begin
        r_awHeld <= 1'b1;
        r_awIdx  <= s_axi_awaddr[5:2];
      end
      if (w_wFire) begin
        r_wHeld  <= 1'b1;
        r_wData  <= s_axi_wdata;
        r_wStrb0 <= s_axi_wstrb[0];
      end
    end
  end

  assign s_axi_bresp = r_bresp;

  // Write decode. CONTROL honours byte 0's strobe; pushes ignore strobes.
  assign w_ctrlWrite = w_doWrite && (w_wrIdx == IDX_CTRL) && w_wrStrb0;
  assign w_flush     = w_ctrlWrite && w_wrData[BIT_FLUSH];
  assign w_push      = w_doWrite && ((w_wrIdx == IDX_TXDATA) || (w_wrIdx == IDX_TXLAST));
  assign w_pushLast  = (w_wrIdx == IDX_TXLAST);
  assign w_pushDrop  = w_push && w_fifoFull;

  // -------------------------------------------------------------------------
  // Control state and stream output
  // -------------------------------------------------------------------------

  // tvalid stays up while a beat is on offer even if TX_EN drops, so the
  // stream never sees a retracted beat; only a flush aborts it.
  assign w_tvalid = !w_fifoEmpty && (r_txEn || r_hold);
  assign w_pop    = w_tvalid && m_axis_tready;

  // TX_EN, sticky overflow and the offered-beat hold flag
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_txEn     <= 1'b0;
      r_overflow <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      if (w_ctrlWrite) r_txEn <= w_wrData[BIT_TX_EN];
      if (w_flush) begin
        r_overflow <= 1'b0;
        r_hold     <= 1'b0;
      end else begin
        if (w_pushDrop) r_overflow <= 1'b1;
        if (w_tvalid)   r_hold     <= !m_axis_tready;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_push     (w_push),
    .i_pushData ({w_pushLast, w_wrData}),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_headData (w_fifoHead),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_fifoHead[DATA_WIDTH-1:0];
  assign m_axis_tlast  = w_fifoHead[DATA_WIDTH];

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------

  // Read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_readState <= R_IDLE;
    else        r_readState <= w_readNext;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    w_readNext    = r_readState;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_readState)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) w_readNext = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) w_readNext = R_IDLE;
      end
      default: w_readNext = R_IDLE;
    endcase
  end

  assign w_arFire = s_axi_arvalid && s_axi_arready;

  // Register read mux; FLUSH is never stored, so CONTROL bit0 reads 0.
  always_comb begin
    w_readValue = DATA_WIDTH'(DEFAULT_RDATA);
    case (s_axi_araddr[5:2])
      IDX_CTRL: begin
        w_readValue            = '0;
        w_readValue[BIT_TX_EN] = r_txEn;
      end
      IDX_STAT: begin
        w_readValue            = '0;
        w_readValue[15:0]      = 16'(w_fifoCount);
        w_readValue[BIT_FULL]  = w_fifoFull;
        w_readValue[BIT_EMPTY] = w_fifoEmpty;
        w_readValue[BIT_OVF]   = r_overflow;
      end
      default: ;
    endcase
  end

  // Read data is captured at the AR handshake and held until taken
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)        r_rdata <= '0;
    else if (w_arFire) r_rdata <= w_readValue;
  end

  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = RESP_OKAY;

endmodule
